// File: rtl/pim_dma_ctrl.sv
// pim_dma_ctrl: word-by-word DMA sequencer between data memory and a PIM unit.
// A one-cycle command from the core starts a MEM2PIM or PIM2MEM transfer.
// dma_busy_o holds the core stalled until the DONE cycle has been shown.
module pim_dma_ctrl #(
  parameter int XLEN   = 32,
  parameter int SIZE_W = 13,
  parameter int CNT_W  = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // command from the EX stage
  input  logic              dma_en_i,
  input  logic [2:0]        dma_funct3_i,
  input  logic [3:0]        dma_sel_pim_i,
  input  logic [SIZE_W-1:0] dma_size_i,
  input  logic [XLEN-1:0]   dma_mem_addr_i,
  output logic              dma_busy_o,
  output logic              dma_done_o,
  output logic              dma_err_o,
  // data-memory master port
  output logic              req_dmem_o,
  input  logic              gnt_dmem_i,
  output logic [XLEN-1:0]   data_addr_o,
  input  logic [XLEN-1:0]   data_rd_data_i,
  output logic [XLEN-1:0]   data_wr_data_o,
  output logic [3:0]        data_size_o,
  output logic              data_read_o,
  output logic              data_write_o,
  // PIM stream port
  output logic [3:0]        pim_sel_o,
  output logic [CNT_W-1:0]  pim_addr_o,
  output logic              pim_wvalid_o,
  input  logic              pim_wready_i,
  output logic [XLEN-1:0]   pim_wdata_o,
  output logic              pim_rreq_o,
  input  logic              pim_rvalid_i,
  input  logic [XLEN-1:0]   pim_rdata_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_PIM_WR  = 3'd3;
  localparam logic [2:0] S_PIM_RD  = 3'd4;
  localparam logic [2:0] S_WR_REQ  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [2:0] F3_MEM2PIM = 3'b000;
  localparam logic [2:0] F3_PIM2MEM = 3'b001;

  logic [2:0]       state_q;
  logic [3:0]       sel_q;
  logic [XLEN-1:0]  addr_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] idx_q;
  logic [1:0]       rem_q;
  logic [XLEN-1:0]  buf_q;
  logic             err_q;

  logic [SIZE_W:0]  size_plus3;
  logic [CNT_W-1:0] words_calc;
  logic             cmd_legal;
  logic             is_last;
  logic [3:0]       wr_mask;

  // Command decode: word count rounds the byte count up, last word may be partial.
  always_comb begin
    size_plus3 = {1'b0, dma_size_i} + (SIZE_W+1)'(3);
    words_calc = CNT_W'(size_plus3 >> 2);
    cmd_legal  = (dma_funct3_i == F3_MEM2PIM) || (dma_funct3_i == F3_PIM2MEM);
    is_last    = (idx_q == (words_q - CNT_W'(1)));
    wr_mask    = 4'b1111;
    if (is_last) begin
      case (rem_q)
        2'd1:    wr_mask = 4'b0001;
        2'd2:    wr_mask = 4'b0011;
        2'd3:    wr_mask = 4'b0111;
        default: wr_mask = 4'b1111;
      endcase
    end
  end

  // Transfer sequencer: state, latched command, word pointers and the one-word buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      words_q <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dma_en_i) begin
            if (!cmd_legal) begin
              err_q <= 1'b1;
            end else begin
              sel_q   <= dma_sel_pim_i;
              addr_q  <= dma_mem_addr_i & ~XLEN'(3);
              words_q <= words_calc;
              rem_q   <= dma_size_i[1:0];
              idx_q   <= '0;
              if (dma_size_i == '0) begin
                state_q <= S_DONE;
              end else if (dma_funct3_i == F3_MEM2PIM) begin
                state_q <= S_RD_REQ;
              end else begin
                state_q <= S_PIM_RD;
              end
            end
          end
        end
        S_RD_REQ: begin
          if (gnt_dmem_i) state_q <= S_RD_DATA;
        end
        S_RD_DATA: begin
          buf_q   <= data_rd_data_i;
          state_q <= S_PIM_WR;
        end
        S_PIM_WR: begin
          if (pim_wready_i) begin
            addr_q  <= addr_q + XLEN'(4);
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= is_last ? S_DONE : S_RD_REQ;
          end
        end
        S_PIM_RD: begin
          if (pim_rvalid_i) begin
            buf_q   <= pim_rdata_i;
            state_q <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (gnt_dmem_i) begin
            addr_q  <= addr_q + XLEN'(4);
            idx_q   <= idx_q + CNT_W'(1);
            state_q <= is_last ? S_DONE : S_PIM_RD;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // A command arriving while a transfer is running is dropped and flagged.
      if (dma_en_i && (state_q != S_IDLE)) err_q <= 1'b1;
    end
  end

  // Port outputs decoded from registered state only, so they stay stable through stalls.
  always_comb begin
    dma_busy_o     = (state_q != S_IDLE);
    dma_done_o     = (state_q == S_DONE);
    dma_err_o      = err_q;
    req_dmem_o     = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
    data_read_o    = (state_q == S_RD_REQ);
    data_write_o   = (state_q == S_WR_REQ);
    data_addr_o    = addr_q;
    data_wr_data_o = (state_q == S_WR_REQ) ? buf_q : '0;
    data_size_o    = 4'b0000;
    if (state_q == S_RD_REQ) data_size_o = 4'b1111;
    if (state_q == S_WR_REQ) data_size_o = wr_mask;
    pim_sel_o      = sel_q;
    pim_addr_o     = idx_q;
    pim_wvalid_o   = (state_q == S_PIM_WR);
    pim_wdata_o    = (state_q == S_PIM_WR) ? buf_q : '0;
    pim_rreq_o     = (state_q == S_PIM_RD);
  end

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// tb_pim_dma_ctrl: directed command table with a memory/PIM responder model,
// plus hand-written sequences for back-pressure, mid-transfer command and reset.
module tb_pim_dma_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dma_en_i;
  logic [2:0]  dma_funct3_i;
  logic [3:0]  dma_sel_pim_i;
  logic [12:0] dma_size_i;
  logic [31:0] dma_mem_addr_i;
  logic        dma_busy_o, dma_done_o, dma_err_o;
  logic        req_dmem_o, gnt_dmem_i;
  logic [31:0] data_addr_o, data_rd_data_i, data_wr_data_o;
  logic [3:0]  data_size_o;
  logic        data_read_o, data_write_o;
  logic [3:0]  pim_sel_o;
  logic [11:0] pim_addr_o;
  logic        pim_wvalid_o, pim_wready_i;
  logic [31:0] pim_wdata_o;
  logic        pim_rreq_o, pim_rvalid_i;
  logic [31:0] pim_rdata_i;

  pim_dma_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .dma_en_i(dma_en_i), .dma_funct3_i(dma_funct3_i), .dma_sel_pim_i(dma_sel_pim_i),
    .dma_size_i(dma_size_i), .dma_mem_addr_i(dma_mem_addr_i),
    .dma_busy_o(dma_busy_o), .dma_done_o(dma_done_o), .dma_err_o(dma_err_o),
    .req_dmem_o(req_dmem_o), .gnt_dmem_i(gnt_dmem_i), .data_addr_o(data_addr_o),
    .data_rd_data_i(data_rd_data_i), .data_wr_data_o(data_wr_data_o),
    .data_size_o(data_size_o), .data_read_o(data_read_o), .data_write_o(data_write_o),
    .pim_sel_o(pim_sel_o), .pim_addr_o(pim_addr_o), .pim_wvalid_o(pim_wvalid_o),
    .pim_wready_i(pim_wready_i), .pim_wdata_o(pim_wdata_o), .pim_rreq_o(pim_rreq_o),
    .pim_rvalid_i(pim_rvalid_i), .pim_rdata_i(pim_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [2:0]  f3;
    logic [3:0]  sel;
    logic [12:0] size;
    logic [31:0] addr;
    int          gstall;
    int          wstall;
    int          rstall;
    int          sword;
    int          poke;
    int          exp_words;
    int          exp_busy;
    int          exp_err;
  } vec_t;

  vec_t vecs [10];

  int total = 0;
  int bad   = 0;

  // model / scoreboard state
  logic [31:0] cur_base;
  logic [3:0]  cur_sel;
  logic [1:0]  cur_rem;
  int          cur_words;
  int rd_cnt, pw_cnt, pr_cnt, wr_cnt, traffic_cnt;
  int busy_cycles, done_cnt, err_cnt;
  int gnt_stall, wr_stall, rv_stall, stall_word;
  logic        rd_pending;
  logic [31:0] rd_pending_addr;
  logic        prev_req, prev_gnt, prev_wr, prev_wv, prev_wrdy;
  logic [31:0] prev_addr, prev_wdata, prev_pwdata;
  logic [3:0]  prev_mask;
  logic [11:0] prev_paddr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A5A_F00F;
  endfunction

  function automatic logic [31:0] pim_word(int k);
    if (k == 0) return 32'hAABB_CCDD;
    if (k == 1) return 32'h1122_3344;
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic logic [3:0] exp_mask(int k);
    if (k == cur_words - 1) begin
      case (cur_rem)
        2'd1:    return 4'b0001;
        2'd2:    return 4'b0011;
        2'd3:    return 4'b0111;
        default: return 4'b1111;
      endcase
    end
    return 4'b1111;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctl"}, {20'd0, dma_busy_o, dma_done_o, dma_err_o, req_dmem_o,
                data_read_o, data_write_o, pim_wvalid_o, pim_rreq_o, data_size_o}, 32'd0);
    checkOutput({tag, "_addr"}, data_addr_o, 32'd0);
    checkOutput({tag, "_wdata"}, data_wr_data_o | pim_wdata_o, 32'd0);
    checkOutput({tag, "_pim"}, {16'd0, pim_sel_o, pim_addr_o}, 32'd0);
  endtask

  task automatic clearHistory();
    prev_req = 0; prev_gnt = 0; prev_wr = 0; prev_wv = 0; prev_wrdy = 0;
    prev_addr = 0; prev_wdata = 0; prev_pwdata = 0; prev_mask = 0; prev_paddr = 0;
    rd_pending = 0; rd_pending_addr = 0;
  endtask

  // Observe one settled cycle: handshakes, stability while stalled, pulse counts.
  task automatic monitor();
    if (dma_busy_o) busy_cycles++;
    if (dma_done_o) done_cnt++;
    if (dma_err_o)  err_cnt++;
    if (req_dmem_o || pim_wvalid_o || pim_rreq_o) traffic_cnt++;
    if (prev_req && !prev_gnt) begin
      checkOutput("req_hold", {31'd0, req_dmem_o}, 32'd1);
      checkOutput("addr_hold", data_addr_o, prev_addr);
      checkOutput("mask_hold", {28'd0, data_size_o}, {28'd0, prev_mask});
      if (prev_wr) checkOutput("wrdata_hold", data_wr_data_o, prev_wdata);
    end
    if (prev_wv && !prev_wrdy) begin
      checkOutput("wvalid_hold", {31'd0, pim_wvalid_o}, 32'd1);
      checkOutput("pwdata_hold", pim_wdata_o, prev_pwdata);
      checkOutput("paddr_hold", {20'd0, pim_addr_o}, {20'd0, prev_paddr});
    end
    if (req_dmem_o && gnt_dmem_i && data_read_o) begin
      checkOutput("rd_addr", data_addr_o, cur_base + 32'(4 * rd_cnt));
      checkOutput("rd_mask", {28'd0, data_size_o}, 32'hF);
      rd_pending      = 1'b1;
      rd_pending_addr = data_addr_o;
      rd_cnt++;
    end
    if (pim_wvalid_o && pim_wready_i) begin
      checkOutput("pw_idx", {20'd0, pim_addr_o}, 32'(pw_cnt));
      checkOutput("pw_data", pim_wdata_o, mem_word(cur_base + 32'(4 * pw_cnt)));
      checkOutput("pw_sel", {28'd0, pim_sel_o}, {28'd0, cur_sel});
      pw_cnt++;
    end
    if (pim_rreq_o && pim_rvalid_i) begin
      checkOutput("pr_idx", {20'd0, pim_addr_o}, 32'(pr_cnt));
      pr_cnt++;
    end
    if (req_dmem_o && gnt_dmem_i && data_write_o) begin
      checkOutput("wr_addr", data_addr_o, cur_base + 32'(4 * wr_cnt));
      checkOutput("wr_data", data_wr_data_o, pim_word(wr_cnt));
      checkOutput("wr_mask", {28'd0, data_size_o}, {28'd0, exp_mask(wr_cnt)});
      checkOutput("wr_sel", {28'd0, pim_sel_o}, {28'd0, cur_sel});
      wr_cnt++;
    end
    prev_req = req_dmem_o; prev_gnt = gnt_dmem_i; prev_wr = data_write_o;
    prev_addr = data_addr_o; prev_wdata = data_wr_data_o; prev_mask = data_size_o;
    prev_wv = pim_wvalid_o; prev_wrdy = pim_wready_i; prev_pwdata = pim_wdata_o;
    prev_paddr = pim_addr_o;
  endtask

  // Advance one clock, drive memory/PIM responses, then observe.
  task automatic step();
    @(posedge clk_i);
    #1;
    data_rd_data_i = rd_pending ? mem_word(rd_pending_addr) : 32'd0;
    rd_pending = 1'b0;
    if (gnt_stall > 0 && req_dmem_o && int'(pim_addr_o) == stall_word) begin
      gnt_dmem_i = 1'b0; gnt_stall--;
    end else gnt_dmem_i = 1'b1;
    if (wr_stall > 0 && pim_wvalid_o && int'(pim_addr_o) == stall_word) begin
      pim_wready_i = 1'b0; wr_stall--;
    end else pim_wready_i = 1'b1;
    if (rv_stall > 0 && pim_rreq_o && int'(pim_addr_o) == stall_word) begin
      pim_rvalid_i = 1'b0; rv_stall--;
    end else pim_rvalid_i = 1'b1;
    pim_rdata_i = pim_word(int'(pim_addr_o));
    #1;
    monitor();
  endtask

  // Load the model for a command and issue the one-cycle strobe.
  task automatic startCmd(input vec_t v);
    cur_base  = v.addr & ~32'd3;
    cur_sel   = v.sel;
    cur_rem   = v.size[1:0];
    cur_words = v.exp_words;
    rd_cnt = 0; pw_cnt = 0; pr_cnt = 0; wr_cnt = 0; traffic_cnt = 0;
    busy_cycles = 0; done_cnt = 0; err_cnt = 0;
    gnt_stall = v.gstall; wr_stall = v.wstall; rv_stall = v.rstall; stall_word = v.sword;
    dma_funct3_i   = v.f3;
    dma_sel_pim_i  = v.sel;
    dma_size_i     = v.size;
    dma_mem_addr_i = v.addr;
    dma_en_i       = 1'b1;
    step();
    dma_en_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int  c;
    bit  m2p;
    m2p = (v.f3 == 3'b000);
    startCmd(v);
    c = 0;
    while (dma_busy_o && c < 500) begin
      if (c == v.poke) begin
        dma_en_i = 1'b1; dma_funct3_i = 3'b001; dma_size_i = 13'd4;
      end
      step();
      dma_en_i = 1'b0;
      c++;
    end
    checkOutput({tag, "_timeout"}, {31'd0, dma_busy_o}, 32'd0);
    step();
    step();
    checkOutput({tag, "_rd_cnt"}, 32'(rd_cnt), m2p ? 32'(v.exp_words) : 32'd0);
    checkOutput({tag, "_pw_cnt"}, 32'(pw_cnt), m2p ? 32'(v.exp_words) : 32'd0);
    checkOutput({tag, "_pr_cnt"}, 32'(pr_cnt), m2p ? 32'd0 : 32'(v.exp_words));
    checkOutput({tag, "_wr_cnt"}, 32'(wr_cnt), m2p ? 32'd0 : 32'(v.exp_words));
    checkOutput({tag, "_busy"}, 32'(busy_cycles), 32'(v.exp_busy));
    checkOutput({tag, "_done"}, 32'(done_cnt), (v.exp_err != 0 && v.poke < 0) ? 32'd0 : 32'd1);
    checkOutput({tag, "_err"}, 32'(err_cnt), 32'(v.exp_err));
    if (v.exp_words == 0) checkOutput({tag, "_traffic"}, 32'(traffic_cnt), 32'd0);
  endtask

  initial begin
    vec_t r;
    int   w;
    //           f3      sel   size    addr          gs ws rs sw  pk  wd busy err
    vecs[0] = '{3'b000, 4'h3, 13'd16, 32'h2000_0102, 0, 0, 0, -1, -1, 4, 13, 0};
    vecs[1] = '{3'b001, 4'h5, 13'd6,  32'h3000_0010, 0, 0, 0, -1, -1, 2, 5,  0};
    vecs[2] = '{3'b000, 4'h1, 13'd10, 32'h1000_0000, 3, 2, 0, 1,  -1, 3, 15, 0};
    vecs[3] = '{3'b000, 4'h2, 13'd0,  32'h0000_0400, 0, 0, 0, -1, -1, 0, 1,  0};
    vecs[4] = '{3'b101, 4'h4, 13'd8,  32'h0000_0800, 0, 0, 0, -1, -1, 0, 0,  1};
    vecs[5] = '{3'b001, 4'hA, 13'd7,  32'hFFFF_FFFE, 1, 0, 2, 1,  -1, 2, 8,  0};
    vecs[6] = '{3'b001, 4'hF, 13'd1,  32'h0000_0040, 0, 0, 0, -1, -1, 1, 3,  0};
    vecs[7] = '{3'b010, 4'h6, 13'd4,  32'h0000_0900, 0, 0, 0, -1, -1, 0, 0,  1};
    vecs[8] = '{3'b000, 4'h9, 13'd5,  32'h0000_0007, 0, 0, 0, -1, -1, 2, 7,  0};
    vecs[9] = '{3'b000, 4'h7, 13'd8,  32'h0000_0100, 0, 0, 0, -1, 2,  2, 7,  1};

    rst_ni = 1'b0;
    dma_en_i = 0; dma_funct3_i = 0; dma_sel_pim_i = 0; dma_size_i = 0; dma_mem_addr_i = 0;
    gnt_dmem_i = 0; pim_wready_i = 0; pim_rvalid_i = 0; data_rd_data_i = 0; pim_rdata_i = 0;
    gnt_stall = 0; wr_stall = 0; rv_stall = 0; stall_word = -1;
    busy_cycles = 0; done_cnt = 0; err_cnt = 0; traffic_cnt = 0;
    rd_cnt = 0; pw_cnt = 0; pr_cnt = 0; wr_cnt = 0;
    cur_base = 0; cur_sel = 0; cur_rem = 0; cur_words = 0;
    clearHistory();
    step();
    step();
    checkAllZero("reset");
    #1 rst_ni = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      $display("[TB] vector %0d", i);
      applyStimulus(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while word 2 sits in PIM_WR with the PIM refusing it.
    $display("[TB] reset during transfer");
    r = '{3'b000, 4'h3, 13'd16, 32'h0000_0500, 0, 1000, 0, 2, -1, 4, 13, 0};
    startCmd(r);
    w = 0;
    while (!(pim_wvalid_o && pim_addr_o == 12'd2) && w < 60) begin
      step();
      w++;
    end
    checkOutput("rst_reach_w2", {20'd0, pim_addr_o}, 32'd2);
    checkOutput("rst_pw_before", 32'(pw_cnt), 32'd2);
    #1 rst_ni = 1'b0;
    #1 checkAllZero("mid_rst");
    clearHistory();
    wr_stall = 0;
    done_cnt = 0;
    busy_cycles = 0;
    step();
    step();
    #1 rst_ni = 1'b1;
    step();
    step();
    step();
    checkOutput("rst_no_done", 32'(done_cnt), 32'd0);
    checkOutput("rst_no_busy", 32'(busy_cycles), 32'd0);
    r = '{3'b000, 4'h3, 13'd16, 32'h0000_0600, 0, 0, 0, -1, -1, 4, 13, 0};
    applyStimulus(r, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got=running want=finished");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/pim_dma_ctrl.md
Name: pim_dma_ctrl

Overview:
- Sequences DMA transfers between data memory and the selected PIM unit, word by word.
- Accepts a one-cycle command pulse from the core EX stage (enable, funct3, PIM select, byte size, memory address).
- Drives a data-memory master port with a req/gnt handshake and a PIM-side stream port.
- Holds dma_busy_o high so the core stays stalled until the transfer completes.

Parameters:
- XLEN, 32, data/address width.
- SIZE_W, 13, width of the byte-count field.
- CNT_W, 12, word-counter width; must hold ceil(2^SIZE_W / 4).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset (asynchronous, active-low)
- dma_en_i  in  1  command strobe, one cycle
- dma_funct3_i  in  3  000 = MEM2PIM, 001 = PIM2MEM, others illegal
- dma_sel_pim_i  in  4  PIM unit select
- dma_size_i  in  SIZE_W  transfer length in bytes
- dma_mem_addr_i  in  XLEN  memory start address
- dma_busy_o  out  1  transfer in progress
- dma_done_o  out  1  one-cycle completion pulse
- dma_err_o  out  1  one-cycle illegal/ignored-command pulse
- req_dmem_o  out  1  data-memory request
- gnt_dmem_i  in  1  data-memory grant
- data_addr_o  out  XLEN  memory word address
- data_rd_data_i  in  XLEN  read data, valid the cycle after a granted read
- data_wr_data_o  out  XLEN  write data
- data_size_o  out  4  byte-enable mask
- data_read_o  out  1  read strobe
- data_write_o  out  1  write strobe
- pim_sel_o  out  4  latched PIM select
- pim_addr_o  out  CNT_W  word index within the transfer
- pim_wvalid_o  out  1  write word valid (MEM2PIM)
- pim_wready_i  in  1  PIM accepts write word
- pim_wdata_o  out  XLEN  write word
- pim_rreq_o  out  1  read request (PIM2MEM)
- pim_rvalid_i  in  1  PIM read data valid
- pim_rdata_i  in  XLEN  PIM read data

Behaviour:
- Reset: all outputs 0; state IDLE; counters and buffer cleared. Reset mid-transfer aborts immediately with no done pulse.
- Acceptance in IDLE with dma_en_i=1:
  - Latch sel, funct3, addr with addr[1:0] forced to 00.
  - words = (size+3)>>2; last-word byte count rem = size[1:0] (0 means 4).
  - dma_busy_o is registered: high from the cycle after acceptance through the DONE cycle inclusive.
- Illegal commands:
  - Illegal funct3 in IDLE: dma_err_o pulses the next cycle, busy stays 0, no transfer.
  - dma_en_i while not IDLE: ignored, dma_err_o pulses.
- size==0: IDLE -> DONE directly; busy high exactly one cycle with dma_done_o; no memory or PIM traffic.
- MEM2PIM: RD_REQ -> RD_DATA -> PIM_WR -> (RD_REQ | DONE).
  - RD_REQ: req_dmem_o=1, data_read_o=1, data_size_o=1111; held until gnt_dmem_i.
  - RD_DATA: capture data_rd_data_i into the buffer (exactly 1 cycle).
  - PIM_WR: pim_wvalid_o=1 with buffer data; advance on pim_wready_i.
- PIM2MEM: PIM_RD -> WR_REQ -> (PIM_RD | DONE).
  - PIM_RD: pim_rreq_o=1 until pim_rvalid_i; capture pim_rdata_i.
  - WR_REQ: req_dmem_o=1, data_write_o=1, data_wr_data_o=buffer; held until gnt_dmem_i.
  - data_size_o=1111, except on the last word: 0001/0011/0111 for rem 1/2/3.
- Per completed word: data_addr_o += 4 and pim_addr_o += 1 (both start at 0 offset). After the last word go to DONE.
- DONE: dma_done_o=1 for one cycle, then IDLE; busy falls the following cycle.
- All request/valid outputs hold stable until their handshake completes. Address and data must not change while req or valid is high.
- data_addr_o wraps modulo 2^XLEN; no boundary checking.
- Grant arrives the same cycle as request at earliest. Minimum MEM2PIM word time is 3 cycles; minimum PIM2MEM word time is 2 cycles.
- req_dmem_o is never high in IDLE or DONE.

Test Plan:
- MEM2PIM, size=16, addr=0x2000_0102, sel=0x3, gnt and ready always high.
  - Reads at 0x2000_0100/104/108/10C; pim_addr_o 0..3 with matching data.
  - Busy high 13 cycles (4 words x 3 + DONE); one done pulse.
- PIM2MEM, size=6, pim data 0xAABBCCDD then 0x11223344.
  - Writes mask 1111 at addr, then 0011 at addr+4.
  - Then done; busy low the next cycle.
- Back-pressure: gnt_dmem_i low 3 cycles and pim_wready_i low 2 cycles mid-transfer.
  - req, addr, wvalid and wdata held stable; no word skipped or repeated; total word count unchanged.
- size=0 -> busy and done high for exactly one cycle; req_dmem_o, pim_wvalid_o, pim_rreq_o stay 0.
- funct3=3'b101 -> dma_err_o pulse, busy stays 0.
- dma_en_i pulsed mid-transfer -> err pulse, transfer unaffected.
- rst_ni low during PIM_WR of word 2 -> all outputs 0 immediately, no done pulse.
  - New command after release executes normally from word 0.
